ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//  EX/MEM pipeline register directly downstream of the 64-bit ALU. Captures the ALU
//  Result/Zero/is_greater, store data and MEM/WB control bits at the end of EX.
//  Resolves conditional branches from the ALU flags and presents a registered
//  taken/target pair to the fetch stage. Supports stall (hold) and flush (bubble).
// PARAMETERS
//  XLEN        64  datapath width (ALU result, PC, immediate, store data)
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk                in   1     clock, all state updates on rising edge
//  reset              in   1     synchronous, active-high; clears all state
//  stall              in   1     1 = hold every registered output unchanged
//  flush              in   1     1 = load a bubble (valid=0, all fields 0)
//  ex_valid           in   1     EX stage holds a real instruction
//  ex_pc              in   XLEN  PC of the EX instruction
//  ex_imm             in   XLEN  sign-extended branch immediate (halfword units)
//  ex_branch          in   2     00 none, 01 beq, 10 bne, 11 bgt (unsigned)
//  ex_alu_result      in   XLEN  ALU Result
//  ex_zero            in   1     ALU Zero
//  ex_is_greater      in   1     ALU is_greater (a > b, unsigned)
//  ex_rs2_data        in   XLEN  store data
//  ex_rd              in   REG_ADDR_W destination register
//  ex_reg_write       in   1     WB writes rd
//  ex_mem_read        in   1     load
//  ex_mem_write       in   1     store
//  ex_mem_to_reg      in   1     WB selects memory data
//  mem_valid          out  1     MEM stage holds a real instruction
//  mem_alu_result     out  XLEN  registered ALU Result (memory address / WB value)
//  mem_rs2_data       out  XLEN  registered store data
//  mem_rd             out  REG_ADDR_W registered destination
//  mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out 1 each, registered
//  mem_branch_taken   out  1     registered branch decision
//  mem_branch_target  out  XLEN  registered ex_pc + (ex_imm << 1)
// BEHAVIOUR
//  - Reset: all outputs 0 on the first rising edge with reset=1.
//  - Priority per edge: reset > flush > stall > load.
//  - Load (no reset/flush/stall): every mem_* output takes its ex_* input; latency
//    is 1 cycle.
//  - Flush: mem_valid=0, all control bits 0, mem_branch_taken=0, data/target
//    fields 0. Flush overrides a simultaneous stall.
//  - Stall: all outputs hold; the EX inputs are ignored and not buffered.
//  - Gating: when ex_valid=0 on load, mem_reg_write, mem_mem_read, mem_mem_write and
//    mem_branch_taken load as 0 regardless of their inputs. Data fields still load.
//  - Branch decision (combinational on ex_*, registered on load):
//    01 beq: taken = ex_zero (ALU performing Sub)
//    10 bne: taken = ~ex_zero
//    11 bgt: taken = ex_is_greater
//    00: taken = 0
//  - Target: computed as ex_pc + {ex_imm[XLEN-2:0],1'b0}, modulo 2^XLEN.
//    Wrap-around is silent. It is registered on every load, whether taken or not.
//  - Stores: mem_mem_read and mem_mem_write are never both checked. Passthrough is
//    bit-exact; the decoder guarantees exclusivity.
//  - Reset asserted mid-stall or mid-flush: reset wins and the state clears.
//    Stall=1 on the first cycle after reset keeps the outputs at 0.
//  - No internal state beyond the output registers; no combinational path
//    from ex_* to mem_*.
// TESTING
//  1. Reset=1 with nonzero ex_* inputs for 2 cycles -> all outputs 0;
//     release -> next edge loads ex_*.
//  2. Load ex_valid=1, alu_result=64'h10, rd=7, reg_write=1 -> next cycle
//     mem_alu_result=64'h10, mem_rd=7, mem_reg_write=1, mem_valid=1.
//  3. beq, zero=1, pc=64'h100, imm=64'h8 -> taken=1, target=64'h110.
//     Then bne with zero=1 -> taken=0.
//  4. bgt, is_greater=1, ex_valid=0 -> mem_branch_taken=0, mem_valid=0.
//     Repeat with ex_valid=1 -> taken=1.
//  5. Stall=1 for 3 cycles while ex_* changes -> outputs frozen.
//     Stall=1 and flush=1 together -> bubble (all 0).
//  6. pc=64'hFFFF_FFFF_FFFF_FFFC, imm=64'h4 -> target=64'h4 (wrap).
//     imm=-2 (all ones except bit0=0) from pc=64'h100 -> target=64'hFC.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU results and MEM/WB control at the end of EX,
// resolves conditional branches from the ALU flags and registers the taken/target pair.
module ex_mem_reg #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [XLEN-1:0]       ex_imm,
  input  logic [1:0]            ex_branch,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic                  ex_zero,
  input  logic                  ex_is_greater,
  input  logic [XLEN-1:0]       ex_rs2_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  output logic                  mem_valid,
  output logic [XLEN-1:0]       mem_alu_result,
  output logic [XLEN-1:0]       mem_rs2_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  mem_branch_taken,
  output logic [XLEN-1:0]       mem_branch_target
);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_GT   = 2'b11;

  logic            taken_c;
  logic [XLEN-1:0] target_c;

  // Branch resolution from ALU flags; the immediate is in halfword units.
  always_comb begin
    taken_c  = 1'b0;
    target_c = ex_pc + {ex_imm[XLEN-2:0], 1'b0};
    case (ex_branch)
      BR_NONE: taken_c = 1'b0;
      BR_EQ:   taken_c = ex_zero;
      BR_NE:   taken_c = ~ex_zero;
      BR_GT:   taken_c = ex_is_greater;
      default: taken_c = 1'b0;
    endcase
  end

  // Priority: reset > flush > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem_valid         <= 1'b0;
      mem_alu_result    <= '0;
      mem_rs2_data      <= '0;
      mem_rd            <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_mem_to_reg    <= 1'b0;
      mem_branch_taken  <= 1'b0;
      mem_branch_target <= '0;
    end else if (!stall) begin
      // Side-effecting controls are gated by ex_valid; data fields load unconditionally.
      mem_valid         <= ex_valid;
      mem_alu_result    <= ex_alu_result;
      mem_rs2_data      <= ex_rs2_data;
      mem_rd            <= ex_rd;
      mem_reg_write     <= ex_valid & ex_reg_write;
      mem_mem_read      <= ex_valid & ex_mem_read;
      mem_mem_write     <= ex_valid & ex_mem_write;
      mem_mem_to_reg    <= ex_mem_to_reg;
      mem_branch_taken  <= ex_valid & taken_c;
      mem_branch_target <= target_c;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg: compares the full output bundle after each edge
// against hand-computed expectations.
module tb_ex_mem_reg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RW    = 5;
  localparam int unsigned OBS_W = 6 + RW + 3 * XLEN;

  logic            clk = 1'b0;
  logic            reset, stall, flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_alu_result, ex_rs2_data;
  logic [1:0]      ex_branch;
  logic            ex_zero, ex_is_greater;
  logic [RW-1:0]   ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_result, mem_rs2_data, mem_branch_target;
  logic [RW-1:0]   mem_rd;
  logic            mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic            mem_branch_taken;

  int vectors    = 0;
  int miscompares = 0;

  logic [OBS_W-1:0] obs, exp_v, held;

  always #5 clk = ~clk;

  ex_mem_reg #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_is_greater(ex_is_greater),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_branch_taken(mem_branch_taken), .mem_branch_target(mem_branch_target)
  );

  assign obs = {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
                mem_branch_taken, mem_rd, mem_alu_result, mem_rs2_data, mem_branch_target};

  // Packs hand-computed expected outputs in the same order as obs.
  function automatic logic [OBS_W-1:0] pack(input logic v, rw, mr, mw, m2r, tk,
                                            input logic [RW-1:0] rd,
                                            input logic [XLEN-1:0] alu, rs2, tgt);
    return {v, rw, mr, mw, m2r, tk, rd, alu, rs2, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_branch = 2'b00; ex_alu_result = '0;
    ex_zero = 1'b0; ex_is_greater = 1'b0; ex_rs2_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    ex_valid = 1'b1; ex_pc = 64'h200; ex_imm = 64'h10; ex_branch = 2'b01; ex_zero = 1'b1;
    ex_alu_result = 64'hAA; ex_rs2_data = 64'hBB; ex_rd = 5'd3;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_cycle%0d: got %h want 0", i, obs);
      end
    end
    reset = 1'b0;
    tick();
    exp_v = pack(1, 1, 1, 0, 1, 1, 5'd3, 64'hAA, 64'hBB, 64'h220);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release_load: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_load();
    clear_inputs();
    ex_valid = 1'b1; ex_alu_result = 64'h10; ex_rd = 5'd7; ex_reg_write = 1'b1;
    ex_rs2_data = 64'hDEAD_BEEF_0123_4567; ex_mem_write = 1'b1;
    tick();
    exp_v = pack(1, 1, 0, 1, 0, 0, 5'd7, 64'h10, 64'hDEAD_BEEF_0123_4567, 64'h0);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL load_basic: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_branch();
    logic [1:0] br[4];
    logic       z[4];
    logic       tk[4];
    br = '{2'b01, 2'b10, 2'b10, 2'b01};
    z  = '{1'b1,  1'b1,  1'b0,  1'b0};
    tk = '{1'b1,  1'b0,  1'b1,  1'b0};
    clear_inputs();
    ex_valid = 1'b1; ex_pc = 64'h100; ex_imm = 64'h8;
    for (int i = 0; i < 4; i++) begin
      ex_branch = br[i]; ex_zero = z[i];
      tick();
      exp_v = pack(1, 0, 0, 0, 0, tk[i], 5'd0, 64'h0, 64'h0, 64'h110);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL branch_%0d br=%b zero=%b: got %h want %h", i, br[i], z[i], obs, exp_v);
      end
    end
  endtask

  task automatic test_gating();
    clear_inputs();
    ex_branch = 2'b11; ex_is_greater = 1'b1; ex_pc = 64'h40; ex_imm = 64'h2;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_mem_to_reg = 1'b1;
    ex_alu_result = 64'h55; ex_rd = 5'd31;
    tick();
    exp_v = pack(0, 0, 0, 0, 1, 0, 5'd31, 64'h55, 64'h0, 64'h44);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL gate_invalid: got %h want %h", obs, exp_v);
    end
    ex_valid = 1'b1; ex_mem_read = 1'b0;
    tick();
    exp_v = pack(1, 1, 0, 1, 1, 1, 5'd31, 64'h55, 64'h0, 64'h44);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL gate_bgt_valid: got %h want %h", obs, exp_v);
    end
    ex_is_greater = 1'b0;
    tick();
    vectors++;
    if (mem_branch_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL bgt_not_greater: got %b want 0", mem_branch_taken);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    ex_valid = 1'b1; ex_alu_result = 64'h1234; ex_rd = 5'd9; ex_reg_write = 1'b1;
    ex_pc = 64'h1000; ex_imm = 64'h20;
    tick();
    held = pack(1, 1, 0, 0, 0, 0, 5'd9, 64'h1234, 64'h0, 64'h1040);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_alu_result = 64'(i + 100); ex_rd = 5'(i + 1); ex_branch = 2'b10;
      ex_valid = i[0]; ex_pc = 64'(i * 8);
      tick();
      vectors++;
      if (obs !== held) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got %h want %h", i, obs, held);
      end
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL stall_flush_bubble: got %h want 0", obs);
    end
    // Stall with reset asserted clears; stall right after reset keeps zeros.
    clear_inputs();
    ex_valid = 1'b1; ex_alu_result = 64'h77; ex_reg_write = 1'b1;
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_during_stall: got %h want 0", obs);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL stall_after_reset: got %h want 0", obs);
    end
    stall = 1'b0;
    tick();
    exp_v = pack(1, 1, 0, 0, 0, 0, 5'd0, 64'h77, 64'h0, 64'h0);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL resume_after_stall: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_wrap();
    clear_inputs();
    ex_valid = 1'b1; ex_pc = 64'hFFFF_FFFF_FFFF_FFFC; ex_imm = 64'h4;
    tick();
    vectors++;
    if (mem_branch_target !== 64'h4) begin
      miscompares++;
      $display("FAIL target_wrap: got %h want %h", mem_branch_target, 64'h4);
    end
    ex_pc = 64'h100; ex_imm = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    vectors++;
    if (mem_branch_target !== 64'hFC) begin
      miscompares++;
      $display("FAIL target_negative: got %h want %h", mem_branch_target, 64'hFC);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load();
    test_branch();
    test_gating();
    test_stall_flush();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
